// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encodings and default timing constants
package pulse_stretcher_pkg;

    // 2'b11 is unused; the FSM treats it as a request to return to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam int unsigned DEF_HOLD_CYCLES = 1000;
    localparam int unsigned DEF_GAP_CYCLES  = 250;
    localparam logic [3:0]  PEND_MAX        = 4'd15;

    function automatic logic [15:0] load_value(input int unsigned cycles);
        return 16'(cycles - 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// rtl/pulse_stretcher_timer.sv - loadable down-counter with zero flag
module cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             ACLR_L,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - event stretcher with HOLD/GAP timing and a 15-deep pending count
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic       CLK,
    input  logic       ACLR_L,
    input  logic       PULSE,
    input  logic       OVF_CLR,
    output logic       LVL,
    output logic       BUSY,
    output logic [3:0] PEND,
    output logic       OVF
);

    localparam logic [15:0] HOLD_LOAD = load_value(HOLD_CYCLES);
    localparam logic [15:0] GAP_LOAD  = load_value(GAP_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  pend_nxt;
    logic        ovf_set;
    logic        queue_evt;
    logic        tmr_load;
    logic [15:0] tmr_val;
    logic        tmr_dec;
    logic        tmr_zero;

    cycle_timer #(
        .WIDTH(16)
    ) u_timer (
        .CLK      (CLK),
        .ACLR_L   (ACLR_L),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            state <= ST_IDLE;
            PEND  <= '0;
            OVF   <= 1'b0;
            LVL   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            PEND  <= pend_nxt;
            OVF   <= ovf_set ? 1'b1 : (OVF_CLR ? 1'b0 : OVF);
            LVL   <= (state_nxt == ST_HOLD);
            BUSY  <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = PEND;
        ovf_set   = 1'b0;
        queue_evt = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = HOLD_LOAD;
        tmr_dec   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (PULSE) begin
                    state_nxt = ST_HOLD;
                    tmr_load  = 1'b1;
                end
            end
            ST_HOLD: begin
                queue_evt = PULSE;
                if (tmr_zero) begin
                    state_nxt = ST_GAP;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_GAP: begin
                // A pulse on the last gap cycle is consumed by the restart itself.
                if (tmr_zero) begin
                    if ((PEND != 4'd0) || PULSE) begin
                        state_nxt = ST_HOLD;
                        tmr_load  = 1'b1;
                        if ((PEND != 4'd0) && !PULSE) begin
                            pend_nxt = PEND - 4'd1;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    queue_evt = PULSE;
                    tmr_dec   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (queue_evt) begin
            if (PEND == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_nxt = PEND + 4'd1;
            end
        end
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000: number of cycles LVL is held high per event; legal range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 250: number of cycles LVL is forced low between back-to-back events; legal range 1..65535.
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 ACLR_L  input  1  reset, asynchronous and active-low.
REQ-005 PULSE  input  1  event strobe, already synchronous and clean; each high cycle counts as one event.
REQ-006 OVF_CLR  input  1  synchronous clear of OVF.
REQ-007 LVL  output  1  stretched level, registered.
REQ-008 BUSY  output  1  high whenever the state is not IDLE, registered.
REQ-009 PEND  output  4  count of queued events not yet started, registered.
REQ-010 OVF  output  1  sticky flag, set when an event is lost to a full queue, registered.

Function
REQ-011 Moore FSM with three states: IDLE, HOLD, GAP; all outputs shall be decoded from registered state only.
REQ-012 A 16-bit down-counter shall time HOLD and GAP; it shall be loaded with HOLD_CYCLES-1 or GAP_CYCLES-1 on state entry.
REQ-013 IDLE: with PULSE=1 at edge k, the FSM shall enter HOLD, and LVL shall be high during cycles k+1..k+HOLD_CYCLES; PEND shall be unchanged.
REQ-014 HOLD: at counter zero, the FSM shall enter GAP; LVL shall be low for exactly GAP_CYCLES cycles.
REQ-015 GAP: at counter zero, the FSM shall enter HOLD and decrement PEND if PEND>0, otherwise enter IDLE.
REQ-016 PULSE=1 in HOLD or GAP shall increment PEND.
REQ-017 PEND saturates at 15; PULSE=1 while PEND=15, with no decrement in the same cycle, shall leave PEND at 15 and set OVF.
REQ-018 Simultaneous increment and decrement (PULSE=1 on the final GAP cycle with PEND>0) shall leave PEND unchanged and start HOLD.
REQ-019 PULSE=1 on the final GAP cycle with PEND=0 shall start HOLD directly and leave PEND at 0; the event shall not be lost.
REQ-020 PULSE=1 on the final HOLD cycle shall increment PEND; the FSM still enters GAP.
REQ-021 OVF_CLR=1 shall clear OVF on the next edge; a simultaneous set condition shall take priority and leave OVF=1.
REQ-022 BUSY shall be high in HOLD and GAP and low in IDLE; LVL shall be high only in HOLD.
REQ-023 Minimum LVL period between consecutive event starts shall be HOLD_CYCLES+GAP_CYCLES cycles.

Reset
REQ-024 ACLR_L=0 shall immediately force state IDLE, counter 0, PEND 0, LVL 0, BUSY 0 and OVF 0, regardless of the clock.
REQ-025 Reset asserted mid-HOLD or mid-GAP shall discard all queued events; after release, no LVL pulse shall occur without a new PULSE.
REQ-026 Release of ACLR_L is synchronised upstream; this block adds no reset synchroniser.

Structure
REQ-027 A shared package shall hold the 2-bit state encodings (IDLE=00, HOLD=01, GAP=10; 11 is illegal and recovers to IDLE) and the default HOLD/GAP constants.
REQ-028 One sub-module, cycle_timer (loadable 16-bit down-counter with zero flag), shall implement the counter; all other logic stays in pulse_stretcher.

Verification
REQ-029 With HOLD=4 and GAP=2, a single PULSE at cycle 10 shall produce LVL=1 on cycles 11-14, BUSY=1 on cycles 11-16, and return to IDLE at cycle 17.
REQ-030 With HOLD=4 and GAP=2, three PULSEs at cycles 10, 11 and 12 shall give PEND 1 then 2, and LVL high on 11-14, 17-20 and 23-26.
REQ-031 Seventeen PULSEs during one HOLD shall give PEND=15 and OVF=1; OVF_CLR shall then drop OVF, and 15 further pulse windows shall follow.
REQ-032 A PULSE on the final GAP cycle, once with PEND=0 and once with PEND=2, shall start HOLD the next cycle with PEND 0 and 2 respectively.
REQ-033 ACLR_L low for one half-cycle mid-HOLD with PEND=3 shall drop LVL, BUSY and PEND to 0 asynchronously, with no LVL activity after release.
REQ-034 A random PULSE stream checked against a reference model shall give a LVL rising-edge count equal to accepted pulses, never exceed PEND 15, and never produce a LVL low gap shorter than GAP_CYCLES.
